csr_file_trap: RTL

- Parametrised successor to the single-bank exception CSR block. Holds the machine CSR set:
  - trap cause and EPC
  - status (IE/PIE/DF)
  - trap vector
  - 64-bit cycle counter and 64-bit instret counter
  - NUM_SCRATCH scratch registers
- Adds a RUN/TRAP state machine with one-cycle redirect pulses on trap entry and trap return, plus write/set/clear CSR operations.
- Sits between decode (read port), the CSR execution unit (write port) and the commit/exception logic.

---
 rtl/csr_file_trap.sv | 125 ++++++++++++
 1 files changed

// File: rtl/csr_file_trap.sv
// csr_file_trap: machine CSR file with RUN/TRAP sequencing, redirect pulses and 64-bit counters.
// Optional same-cycle read bypass of CSR writes when CSR_BYPASS_EN is defined.
module csr_file_trap #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 12,
  parameter int CAUSE_W = 5,
  parameter int NUM_SCRATCH = 4,
  parameter logic [XLEN-1:0] RESET_TVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [XLEN-1:0]    rd_data,
  output logic               rd_illegal,
  input  logic               wr_valid,
  input  logic [1:0]         wr_op,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [XLEN-1:0]    wr_data,
  output logic               wr_err,
  input  logic               exc_valid,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic               ret_valid,
  input  logic               retire,
  output logic               trap_redirect,
  output logic               ret_redirect,
  output logic [XLEN-1:0]    trap_target,
  output logic               in_trap,
  output logic               double_fault,
  output logic               irq_en
);
  typedef enum logic {RUN, TRAP} state_t;
  localparam logic [XLEN-1:0] CSR_ID = XLEN'({8'(NUM_SCRATCH), 8'(CAUSE_W), 16'hC5A1});
  state_t state, state_nxt;
  logic [XLEN-1:0] scratch [NUM_SCRATCH];
  logic [XLEN-1:0] cause, epc, tvec;
  logic [2:0] status;
  logic [2*XLEN-1:0] cycle, instret;
  logic take_trap, take_ret, df_set;
  logic wr_map, wr_ok, wr_do, rd_map;
  logic [XLEN-1:0] wr_old, wr_new, wr_val, rd_reg;
  function automatic logic [XLEN:0] csr_rd(input logic [ADDR_W-1:0] a);
    logic [XLEN:0] r;
    r = '0;
    case (a)
      ADDR_W'('h1): r = {1'b1, cause};
      ADDR_W'('h2): r = {1'b1, epc};
      ADDR_W'('h3): r = {1'b1, {(XLEN-3){1'b0}}, status};
      ADDR_W'('h4): r = {1'b1, tvec};
      ADDR_W'('h5): r = {1'b1, cycle[XLEN-1:0]};
      ADDR_W'('h6): r = {1'b1, cycle[2*XLEN-1:XLEN]};
      ADDR_W'('h7): r = {1'b1, instret[XLEN-1:0]};
      ADDR_W'('h8): r = {1'b1, instret[2*XLEN-1:XLEN]};
      ADDR_W'('hA): r = {1'b1, CSR_ID};
      default:
        for (int i = 0; i < NUM_SCRATCH; i++)
          if (a == ADDR_W'(i == 0 ? 0 : 15 + i)) r = {1'b1, scratch[i]};
    endcase
    return r;
  endfunction
  assign {wr_map, wr_old} = csr_rd(wr_addr);
  assign {rd_map, rd_reg} = csr_rd(rd_addr);
  assign wr_ok = wr_map && wr_addr != ADDR_W'('hA);
  // exception bookkeeping owns EPC/CAUSE/STATUS in its cycle; colliding writes vanish silently
  assign wr_do = wr_valid && wr_op != 2'b00 && wr_ok &&
                 !(exc_valid && (wr_addr == ADDR_W'('h1) || wr_addr == ADDR_W'('h2) || wr_addr == ADDR_W'('h3)));
  assign wr_new = wr_op == 2'b01 ? wr_data : wr_op == 2'b10 ? (wr_old | wr_data) : (wr_old & ~wr_data);
  assign wr_val = wr_addr == ADDR_W'('h3) ? {{(XLEN-3){1'b0}}, wr_new[2:0]} :
                  wr_addr == ADDR_W'('h4) ? {wr_new[XLEN-1:2], 2'b00} : wr_new;
`ifdef CSR_BYPASS_EN
  assign rd_data = (wr_do && wr_addr == rd_addr) ? wr_val : rd_reg;
`else
  assign rd_data = rd_reg;
`endif
  assign rd_illegal = !rd_map;
  assign in_trap = state == TRAP;
  assign double_fault = status[2];
  assign irq_en = status[0];
  always_comb begin
    take_trap = state == RUN && exc_valid;
    df_set = state == TRAP && exc_valid;
    take_ret = state == TRAP && !exc_valid && ret_valid;
    state_nxt = take_trap ? TRAP : take_ret ? RUN : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
      cause <= '0;
      epc <= '0;
      status <= '0;
      tvec <= RESET_TVEC;
      cycle <= '0;
      instret <= '0;
      wr_err <= 1'b0;
      trap_redirect <= 1'b0;
      ret_redirect <= 1'b0;
      trap_target <= '0;
    end else begin
      wr_err <= wr_valid && wr_op != 2'b00 && !wr_ok;
      trap_redirect <= take_trap;
      ret_redirect <= take_ret;
      trap_target <= take_trap ? tvec : take_ret ? epc : '0;
      cycle <= wr_do && wr_addr == ADDR_W'('h5) ? {cycle[2*XLEN-1:XLEN], wr_val} :
               wr_do && wr_addr == ADDR_W'('h6) ? {wr_val, cycle[XLEN-1:0]} : cycle + 1'b1;
      instret <= wr_do && wr_addr == ADDR_W'('h7) ? {instret[2*XLEN-1:XLEN], wr_val} :
                 wr_do && wr_addr == ADDR_W'('h8) ? {wr_val, instret[XLEN-1:0]} :
                 instret + {{(2*XLEN-1){1'b0}}, retire};
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (wr_do && wr_addr == ADDR_W'(i == 0 ? 0 : 15 + i)) scratch[i] <= wr_val;
      if (wr_do && wr_addr == ADDR_W'('h1)) cause <= wr_val;
      if (wr_do && wr_addr == ADDR_W'('h2)) epc <= wr_val;
      if (wr_do && wr_addr == ADDR_W'('h3)) status <= wr_val[2:0];
      if (wr_do && wr_addr == ADDR_W'('h4)) tvec <= wr_val;
      if (take_trap) begin
        epc <= exc_pc;
        cause <= XLEN'(exc_cause);
        status <= {status[2], status[0], 1'b0};
      end
      if (df_set) status[2] <= 1'b1;
      if (take_ret) status <= {status[2], 1'b1, status[1]};
    end
endmodule
